ex_muldiv: RTL and testbench

Iterative RV32M multiply/divide unit in the EX stage, consuming the instruction fields and operands presented by the ID/EX pipeline register. It detects M-extension instructions, computes the result over multiple cycles, and drives `stall_o` back into the ID/EX register's stall input so the instruction is held in place until the result is ready. Pipeline flush aborts any in-flight operation.

---
 rtl/ex_muldiv.sv | 182 ++++++++++++++++++
 tb/tb_ex_muldiv.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage. It holds ID/EX through stall_o
// until the result is ready. Multiply takes one cycle and divide is restoring radix-2.
module ex_muldiv (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic        hold_i,
  input  logic [6:0]  op_i,
  input  logic [7:0]  funct7_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] data1_i,
  input  logic [31:0] data2_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [7:0] F7_MULDIV = 8'h01;
  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return (~v) + 32'd1;
  endfunction

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [63:0] acc_q, acc_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic [31:0] result_q, result_d;
  logic        done_q, done_d;

  logic        req_s, start_s;
  logic        div_signed_s, div_zero_s, div_ovf_s;
  logic [31:0] dvd_mag_s, dsr_mag_s;
  logic [63:0] mul_a_s, mul_b_s, prod_s;
  logic [32:0] trial_s;
  logic [63:0] acc_step_s;
  logic [31:0] quo_fix_s, rem_fix_s;

  assign req_s   = (op_i == OP_REG) && (funct7_i == F7_MULDIV);
  assign start_s = req_s && !flush_i;

  // Divide operand decode works on the live ID/EX fields so special cases resolve in IDLE.
  assign div_signed_s = ~funct3_i[0];
  assign div_zero_s   = (data2_i == 32'd0);
  assign div_ovf_s    = div_signed_s && (data1_i == 32'h8000_0000) && (data2_i == 32'hFFFF_FFFF);
  assign dvd_mag_s    = (div_signed_s && data1_i[31]) ? neg32(data1_i) : data1_i;
  assign dsr_mag_s    = (div_signed_s && data2_i[31]) ? neg32(data2_i) : data2_i;

  // Extending both operands to 64 bits keeps the low 64 bits of the product exact for every sign mix.
  assign mul_a_s = ((f3_q == F3_MULH) || (f3_q == F3_MULHSU)) ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
  assign mul_b_s = (f3_q == F3_MULH) ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
  assign prod_s  = mul_a_s * mul_b_s;

  // acc holds {partial remainder, dividend bits still to shift in / quotient bits shifted out}.
  assign trial_s    = acc_q[63:31] - {1'b0, b_q};
  assign acc_step_s = trial_s[32] ? {acc_q[62:0], 1'b0} : {trial_s[31:0], acc_q[30:0], 1'b1};
  assign quo_fix_s  = neg_quo_q ? neg32(acc_step_s[31:0]) : acc_step_s[31:0];
  assign rem_fix_s  = neg_rem_q ? neg32(acc_step_s[63:32]) : acc_step_s[63:32];

  assign stall_o  = rst_n && (((state_q == S_IDLE) && start_s) || (state_q == S_MUL) || (state_q == S_DIV));
  assign done_o   = done_q;
  assign result_o = result_q;
  assign busy_o   = (state_q != S_IDLE);

  // Next-state, operand capture and datapath update.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    f3_d      = f3_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    done_d    = 1'b0;
    if (flush_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_s) begin
            f3_d  = funct3_i;
            a_d   = data1_i;
            b_d   = data2_i;
            cnt_d = 5'd0;
            if (!funct3_i[2]) begin
              state_d = S_MUL;
            end else if (div_zero_s) begin
              state_d  = S_DONE;
              done_d   = 1'b1;
              result_d = funct3_i[1] ? data1_i : 32'hFFFF_FFFF;
            end else if (div_ovf_s) begin
              state_d  = S_DONE;
              done_d   = 1'b1;
              result_d = funct3_i[1] ? 32'd0 : 32'h8000_0000;
            end else begin
              state_d   = S_DIV;
              b_d       = dsr_mag_s;
              acc_d     = {32'd0, dvd_mag_s};
              neg_quo_d = div_signed_s && (data1_i[31] ^ data2_i[31]);
              neg_rem_d = div_signed_s && data1_i[31];
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_MUL: begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          result_d = (f3_q == F3_MUL) ? prod_s[31:0] : prod_s[63:32];
        end
        S_DIV: begin
          acc_d = acc_step_s;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            result_d = f3_q[1] ? rem_fix_s : quo_fix_s;
          end else begin
            state_d = S_DIV;
          end
        end
        S_DONE: begin
          if (hold_i) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 5'd0;
      f3_q      <= 3'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      acc_q     <= 64'd0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= 32'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      f3_q      <= f3_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Randomized self-checking bench for ex_muldiv. Results come from a plain-arithmetic RV32M
// model, and timing comes from the documented per-family latencies.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_i;
  logic        hold_i;
  logic [6:0]  op_i;
  logic [7:0]  funct7_i;
  logic [2:0]  funct3_i;
  logic [31:0] data1_i;
  logic [31:0] data2_i;
  logic        stall_o;
  logic        done_o;
  logic [31:0] result_o;
  logic        busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ex_muldiv dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush_i  (flush_i),
    .hold_i   (hold_i),
    .op_i     (op_i),
    .funct7_i (funct7_i),
    .funct3_i (funct3_i),
    .data1_i  (data1_i),
    .data2_i  (data2_i),
    .stall_o  (stall_o),
    .done_o   (done_o),
    .result_o (result_o),
    .busy_o   (busy_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint          ps;
    longint unsigned ua;
    longint unsigned ub;
    longint unsigned pu;
    logic            ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin ps = sa * sb; return ps[31:0]; end
      3'd1: begin ps = sa * sb; return ps[63:32]; end
      3'd2: begin ps = sa * $signed(ub); return ps[63:32]; end
      3'd3: begin pu = ua * ub; return pu[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        ps = sa / sb;
        return ps[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        pu = ua / ub;
        return pu[31:0];
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (ovf) return 32'd0;
        ps = sa % sb;
        return ps[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        pu = ua % ub;
        return pu[31:0];
      end
    endcase
  endfunction

  // Cycle of the DONE state, counted from the first cycle the request is seen.
  function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return 2;
    if (b == 32'd0) return 1;
    if (!f3[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 1;
    return 33;
  endfunction

  task automatic drive_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    op_i     = 7'b0110011;
    funct7_i = 8'h01;
    funct3_i = f3;
    data1_i  = a;
    data2_i  = b;
  endtask

  task automatic drive_nop();
    op_i     = 7'b0010011;
    funct7_i = 8'h00;
    funct3_i = 3'd0;
    data1_i  = 32'd0;
    data2_i  = 32'd0;
  endtask

  // Entered just after a rising edge with the unit idle; returns just after the edge ending DONE.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp_r;
    int          lat;
    exp_r = ref_result(f3, a, b);
    lat   = ref_latency(f3, a, b);
    drive_m(f3, a, b);
    for (int c = 0; c <= lat; c++) begin
      @(negedge clk);
      check_eq($sformatf("stall f3=%0d c=%0d", f3, c), {31'd0, stall_o}, (c < lat) ? 32'd1 : 32'd0);
      check_eq($sformatf("done f3=%0d c=%0d", f3, c), {31'd0, done_o}, (c == lat) ? 32'd1 : 32'd0);
      check_eq($sformatf("busy f3=%0d c=%0d", f3, c), {31'd0, busy_o}, (c != 0) ? 32'd1 : 32'd0);
      if (c == lat) begin
        check_eq($sformatf("result f3=%0d a=%h b=%h", f3, a, b), result_o, exp_r);
      end
      @(posedge clk);
      #1;
    end
    drive_nop();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  rf3;
    logic [31:0] ra;
    logic [31:0] rb;
    int          sel;

    rst_n   = 1'b0;
    flush_i = 1'b0;
    hold_i  = 1'b0;
    drive_nop();
    #3;
    check_eq("reset stall", {31'd0, stall_o}, 32'd0);
    check_eq("reset done", {31'd0, done_o}, 32'd0);
    check_eq("reset busy", {31'd0, busy_o}, 32'd0);
    check_eq("reset result", result_o, 32'd0);
    #9;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases with known answers.
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'd4, 32'd100, 32'd7);
    run_op(3'd6, 32'hFFFF_FF9C, 32'd7);
    run_op(3'd5, 32'd5, 32'd0);
    run_op(3'd7, 32'd5, 32'd0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    check_eq("mulhu max", ref_result(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);

    // Flush in the middle of a divide.
    drive_m(3'd4, 32'd100, 32'd7);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check_eq("flush pre stall", {31'd0, stall_o}, 32'd1);
      @(posedge clk);
      #1;
    end
    flush_i = 1'b1;
    @(negedge clk);
    check_eq("flush cycle done", {31'd0, done_o}, 32'd0);
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    drive_nop();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check_eq("flush post stall", {31'd0, stall_o}, 32'd0);
      check_eq("flush post done", {31'd0, done_o}, 32'd0);
      check_eq("flush post busy", {31'd0, busy_o}, 32'd0);
      @(posedge clk);
      #1;
    end
    run_op(3'd5, 32'd9, 32'd2);

    // External hold keeps DONE and the result stable.
    drive_m(3'd0, 32'd6, 32'd7);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
    end
    hold_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq("hold done", {31'd0, done_o}, 32'd1);
      check_eq("hold result", result_o, 32'd42);
      check_eq("hold stall", {31'd0, stall_o}, 32'd0);
      @(posedge clk);
      #1;
    end
    hold_i = 1'b0;
    drive_nop();
    @(negedge clk);
    check_eq("hold last done", {31'd0, done_o}, 32'd1);
    check_eq("hold last result", result_o, 32'd42);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("hold release done", {31'd0, done_o}, 32'd0);
    check_eq("hold release busy", {31'd0, busy_o}, 32'd0);
    @(posedge clk);
    #1;

    // Reset in the middle of a divide, with the request still presented.
    drive_m(3'd5, 32'd1000, 32'd3);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    check_eq("midrst stall", {31'd0, stall_o}, 32'd0);
    check_eq("midrst done", {31'd0, done_o}, 32'd0);
    check_eq("midrst busy", {31'd0, busy_o}, 32'd0);
    check_eq("midrst result", result_o, 32'd0);
    drive_nop();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Non-M instructions never start the unit.
    for (int c = 0; c < 4; c++) begin
      op_i     = 7'b0110011;
      funct7_i = (c < 2) ? 8'h00 : 8'h20;
      funct3_i = 3'(c);
      data1_i  = $urandom;
      data2_i  = $urandom;
      @(negedge clk);
      check_eq("nonm stall", {31'd0, stall_o}, 32'd0);
      check_eq("nonm busy", {31'd0, busy_o}, 32'd0);
      @(posedge clk);
      #1;
    end
    op_i     = 7'b0110111;
    funct7_i = 8'h01;
    @(negedge clk);
    check_eq("nonm opcode stall", {31'd0, stall_o}, 32'd0);
    @(posedge clk);
    #1;
    drive_nop();

    // Randomized operations, biased toward the divide corner cases.
    for (int i = 0; i < 48; i++) begin
      rf3 = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 9);
      ra  = $urandom;
      rb  = $urandom;
      case (sel)
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = $urandom_range(1, 20);
        3: ra = $urandom_range(0, 1000);
        4: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
        default: ra = ra;
      endcase
      run_op(rf3, ra, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
